// File: rtl/transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : transfer_ctrl
// Description : Register-to-register / immediate-to-register transfer
//               controller for a shared tri-state data bus. A request is
//               accepted in IDLE, then the source register (oe) or the
//               latched immediate drives the bus for DRIVE and LOAD, the
//               destination is strobed (notLoad) in LOAD, and a one-cycle
//               done (optionally qualified by err) closes the transfer.
//               Invalid requests skip straight to DONE with err set.
// Ports       : clock, reset          - clock, synchronous active-high reset
//               req_valid/req_ready   - request handshake
//               req_src/req_dst       - source / destination register index
//               req_imm_en/req_imm    - immediate source select and value
//               oe                    - per-register output enable (active-high)
//               notLoad               - per-register load strobe (active-low)
//               bus                   - shared tri-state data bus
//               last_value            - bus value of last completed load
//               done/err              - completion pulse and reject flag
// Revision    : 1.0 - initial release
// ============================================================================
module transfer_ctrl #(
   parameter int NUM_REGS   = 8,
   parameter int IDX_WIDTH  = 3,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [IDX_WIDTH-1:0]  req_src,
   input  logic [IDX_WIDTH-1:0]  req_dst,
   input  logic                  req_imm_en,
   input  logic [DATA_WIDTH-1:0] req_imm,
   output logic [NUM_REGS-1:0]   oe,
   output logic [NUM_REGS-1:0]   notLoad,
   inout  wire  [DATA_WIDTH-1:0] bus,
   output logic [DATA_WIDTH-1:0] last_value,
   output logic                  done,
   output logic                  err
);

   // ------------------------------------------------------------------------
   // State encoding
   // ------------------------------------------------------------------------
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DRIVE = 2'd1;
   localparam logic [1:0] LOAD  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   // One extra bit so the range check also works when NUM_REGS equals
   // 2**IDX_WIDTH (every index in range).
   localparam logic [IDX_WIDTH:0] C_NUM_REGS = (IDX_WIDTH + 1)'(NUM_REGS);

   // ------------------------------------------------------------------------
   // State and latched request
   // ------------------------------------------------------------------------
   logic [1:0]            state_q,      state_d;
   logic [IDX_WIDTH-1:0]  src_q,        src_d;
   logic [IDX_WIDTH-1:0]  dst_q,        dst_d;
   logic                  imm_en_q,     imm_en_d;
   logic [DATA_WIDTH-1:0] imm_q,        imm_d;
   logic                  invalid_q,    invalid_d;
   logic [DATA_WIDTH-1:0] last_value_q, last_value_d;

   logic                  req_invalid;
   logic                  drive_phase;
   logic                  imm_drive;

   // Validity is judged on the values being latched, so the flag stored with
   // the request always describes the request that is in flight.
   always_comb begin
      req_invalid = 1'b0;
      if ({1'b0, req_dst} >= C_NUM_REGS) begin
         req_invalid = 1'b1;
      end else if (!req_imm_en) begin
         if (({1'b0, req_src} >= C_NUM_REGS) || (req_src == req_dst)) begin
            req_invalid = 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      dst_d        = dst_q;
      imm_en_d     = imm_en_q;
      imm_d        = imm_q;
      invalid_d    = invalid_q;
      last_value_d = last_value_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               src_d     = req_src;
               dst_d     = req_dst;
               imm_en_d  = req_imm_en;
               imm_d     = req_imm;
               invalid_d = req_invalid;
               state_d   = req_invalid ? DONE : DRIVE;
            end
         end
         DRIVE: begin
            state_d = LOAD;
         end
         LOAD: begin
            // The destination register samples the bus on this same edge;
            // keep a copy of what it received.
            last_value_d = bus;
            state_d      = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         src_q        <= '0;
         dst_q        <= '0;
         imm_en_q     <= 1'b0;
         imm_q        <= '0;
         invalid_q    <= 1'b0;
         last_value_q <= '0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         imm_en_q     <= imm_en_d;
         imm_q        <= imm_d;
         invalid_q    <= invalid_d;
         last_value_q <= last_value_d;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode: registered state and latched fields only, so the bus
   // controls never glitch with the request inputs.
   // ------------------------------------------------------------------------
   assign drive_phase = (state_q == DRIVE) || (state_q == LOAD);
   assign imm_drive   = drive_phase && imm_en_q;

   generate
      for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_ctrl
         localparam logic [IDX_WIDTH-1:0] C_IDX = IDX_WIDTH'(i);
         // An immediate transfer never enables a register onto the bus, so
         // at most one driver is ever active.
         assign oe[i]      = drive_phase && !imm_en_q && (src_q == C_IDX);
         assign notLoad[i] = !((state_q == LOAD) && (dst_q == C_IDX));
      end
   endgenerate

   assign bus        = imm_drive ? imm_q : {DATA_WIDTH{1'bz}};
   assign done       = (state_q == DONE);
   assign err        = (state_q == DONE) && invalid_q;
   assign req_ready  = (state_q == IDLE) && !reset;
   assign last_value = last_value_q;

endmodule
`default_nettype wire

// File: tb/tb_transfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_transfer_ctrl
// Description : Testbench for transfer_ctrl. Models a register file hanging
//               off the shared bus (oe drives, notLoad captures) and checks
//               the controller against transfer-level expectations.
//               NUM_REGS is set below 2**IDX_WIDTH so out-of-range indices
//               can be exercised.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transfer_ctrl;

   localparam int NR = 6;
   localparam int IW = 3;
   localparam int DW = 16;
   localparam logic [NR-1:0] NL_IDLE   = '1;
   localparam logic [DW-1:0] BUS_FLOAT = '0;   // pulled-down idle bus value

   logic          clock      = 1'b0;
   logic          reset      = 1'b1;
   logic          req_valid  = 1'b0;
   logic [IW-1:0] req_src    = '0;
   logic [IW-1:0] req_dst    = '0;
   logic          req_imm_en = 1'b0;
   logic [DW-1:0] req_imm    = '0;
   wire           req_ready;
   wire  [NR-1:0] oe;
   wire  [NR-1:0] notLoad;
   wire  [DW-1:0] bus;
   wire  [DW-1:0] last_value;
   wire           done;
   wire           err;

   logic [DW-1:0] regs       [NR];
   logic [DW-1:0] model_regs [NR];
   logic          preload_en  = 1'b0;
   logic [IW-1:0] preload_idx = '0;
   logic [DW-1:0] preload_val = '0;
   logic [DW-1:0] reg_drive;
   logic          reg_drive_en;
   bit            mon_on = 1'b0;

   int errors = 0;
   int checks = 0;

   transfer_ctrl #(
      .NUM_REGS   (NR),
      .IDX_WIDTH  (IW),
      .DATA_WIDTH (DW)
   ) u_dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_src    (req_src),
      .req_dst    (req_dst),
      .req_imm_en (req_imm_en),
      .req_imm    (req_imm),
      .oe         (oe),
      .notLoad    (notLoad),
      .bus        (bus),
      .last_value (last_value),
      .done       (done),
      .err        (err)
   );

   always #5 clock = ~clock;

   // Register file on the bus
   generate
      for (genvar b = 0; b < DW; b++) begin : g_pd
         pulldown (bus[b]);
      end
   endgenerate

   always_comb begin
      reg_drive    = '0;
      reg_drive_en = 1'b0;
      for (int i = 0; i < NR; i++) begin
         if (oe[i] === 1'b1) begin
            reg_drive_en = 1'b1;
            reg_drive    = regs[i];
         end
      end
   end

   assign bus = reg_drive_en ? reg_drive : {DW{1'bz}};

   always @(posedge clock) begin
      if (preload_en) begin
         regs[preload_idx] <= preload_val;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (notLoad[i] === 1'b0) regs[i] <= bus;
         end
      end
   end

   // Reference helpers (transfer-level rules)
   function automatic logic [NR-1:0] onehot(input int idx);
      logic [NR-1:0] v;
      v = '0;
      if (idx >= 0 && idx < NR) v[idx] = 1'b1;
      return v;
   endfunction

   function automatic bit is_invalid(input int s, input int d, input bit ie);
      return (d >= NR) || (!ie && (s >= NR || s == d));
   endfunction

   // Presents one request for one cycle; returns at the following negedge.
   task automatic send(input logic [IW-1:0] s, input logic [IW-1:0] d,
                       input logic ie, input logic [DW-1:0] im);
      req_valid  = 1'b1;
      req_src    = s;
      req_dst    = d;
      req_imm_en = ie;
      req_imm    = im;
      @(negedge clock);
      req_valid  = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   task automatic test_invariants();
      forever begin
         @(negedge clock);
         if (mon_on) begin
            checks++;
            if ($countones(oe) > 1 || $countones(~notLoad) > 1 ||
                (reg_drive_en && bus !== reg_drive)) begin
               errors++;
               $display("FAIL invariants: oe=%b notLoad=%b bus=%h reg_drive=%h",
                        oe, notLoad, bus, reg_drive);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req_valid = 1'b1;
      req_src   = 3'd1;
      req_dst   = 3'd2;
      @(negedge clock);
      for (int i = 0; i < NR; i++) begin
         preload_en    = 1'b1;
         preload_idx   = IW'(i);
         preload_val   = (i == 2) ? 16'h1234 : DW'($urandom_range(1, 16'hFFFF));
         model_regs[i] = preload_val;
         @(negedge clock);
      end
      preload_en = 1'b0;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ready: got %b want 0", req_ready);
      end
      checks++;
      if (oe !== '0 || notLoad !== NL_IDLE || done !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: oe=%b notLoad=%b done=%b err=%b want 0/all1/0/0",
                  oe, notLoad, done, err);
      end
      checks++;
      if (last_value !== '0) begin
         errors++; $display("FAIL reset_last_value: got %h want 0", last_value);
      end
      mon_on    = 1'b1;
      req_valid = 1'b0;
      reset     = 1'b0;
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1 || bus !== BUS_FLOAT) begin
         errors++;
         $display("FAIL reset_release: ready=%b bus=%h want 1/%h", req_ready, bus, BUS_FLOAT);
      end
      repeat (3) @(negedge clock);
      begin
         bit ok;
         ok = (done === 1'b0);
         for (int i = 0; i < NR; i++) if (regs[i] !== model_regs[i]) ok = 1'b0;
         checks++;
         if (!ok) begin
            errors++; $display("FAIL reset_no_accept: done=%b or register file changed", done);
         end
      end
   endtask

   task automatic test_reg_to_reg();
      send(3'd2, 3'd5, 1'b0, 16'h0);
      checks++;
      if (oe !== onehot(2) || notLoad !== NL_IDLE || done !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL r2r_drive: oe=%b notLoad=%b done=%b ready=%b", oe, notLoad, done, req_ready);
      end
      @(negedge clock);
      checks++;
      if (oe !== onehot(2) || notLoad !== ~onehot(5) || bus !== 16'h1234) begin
         errors++;
         $display("FAIL r2r_load: oe=%b notLoad=%b bus=%h want %b/%b/1234",
                  oe, notLoad, bus, onehot(2), ~onehot(5));
      end
      @(negedge clock);
      model_regs[5] = 16'h1234;
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || last_value !== 16'h1234 || regs[5] !== 16'h1234 ||
          oe !== '0 || notLoad !== NL_IDLE) begin
         errors++;
         $display("FAIL r2r_done: done=%b err=%b last=%h reg5=%h oe=%b", done, err,
                  last_value, regs[5], oe);
      end
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL r2r_idle: ready=%b done=%b want 1/0", req_ready, done);
      end
   endtask

   task automatic test_immediate();
      send(3'd4, 3'd0, 1'b1, 16'hBEEF);
      checks++;
      if (oe !== '0 || bus !== 16'hBEEF || notLoad !== NL_IDLE) begin
         errors++; $display("FAIL imm_drive: oe=%b bus=%h notLoad=%b", oe, bus, notLoad);
      end
      @(negedge clock);
      checks++;
      if (oe !== '0 || bus !== 16'hBEEF || notLoad !== ~onehot(0)) begin
         errors++; $display("FAIL imm_load: oe=%b bus=%h notLoad=%b", oe, bus, notLoad);
      end
      @(negedge clock);
      model_regs[0] = 16'hBEEF;
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || regs[0] !== 16'hBEEF || last_value !== 16'hBEEF ||
          bus !== BUS_FLOAT) begin
         errors++;
         $display("FAIL imm_done: done=%b err=%b reg0=%h last=%h bus=%h", done, err,
                  regs[0], last_value, bus);
      end
      @(negedge clock);
   endtask

   task automatic test_invalid();
      send(3'd3, 3'd3, 1'b0, 16'h5A5A);
      checks++;
      if (done !== 1'b1 || err !== 1'b1 || oe !== '0 || notLoad !== NL_IDLE ||
          req_ready !== 1'b0 || last_value !== 16'hBEEF) begin
         errors++;
         $display("FAIL invalid_done: done=%b err=%b oe=%b notLoad=%b ready=%b last=%h",
                  done, err, oe, notLoad, req_ready, last_value);
      end
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
         errors++; $display("FAIL invalid_idle: ready=%b done=%b err=%b", req_ready, done, err);
      end
   endtask

   task automatic test_boundary_idx();
      logic [IW-1:0] t_src [5] = '{3'd1, 3'd7, 3'd6, 3'd7, 3'd0};
      logic [IW-1:0] t_dst [5] = '{3'd6, 3'd1, 3'd0, 3'd4, 3'd7};
      logic          t_ie  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic          t_bad [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 5; k++) begin
         logic [DW-1:0] im;
         im = DW'($urandom_range(1, 16'hFFFF));
         send(t_src[k], t_dst[k], t_ie[k], im);
         if (!t_bad[k]) begin
            repeat (2) @(negedge clock);
            model_regs[t_dst[k]] = im;
         end
         checks++;
         if (done !== 1'b1 || err !== t_bad[k] ||
             (!t_bad[k] && regs[t_dst[k]] !== im)) begin
            errors++;
            $display("FAIL boundary_idx[%0d]: done=%b err=%b want 1/%b", k, done, err, t_bad[k]);
         end
         @(negedge clock);
      end
   endtask

   task automatic test_back_to_back();
      int            done_at [$];
      logic [IW-1:0] dst_q   [$];
      logic [DW-1:0] val_q   [$];
      int            next_free;
      int            completed;
      next_free = 0;
      completed = 0;
      req_imm_en = 1'b0;
      for (int n = 0; n < 14; n++) begin
         bit exp_done;
         exp_done = (done_at.size() > 0) && (done_at[0] == n);
         checks++;
         if (done !== exp_done || err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done cycle %0d: done=%b err=%b want %b/0", n, done, err, exp_done);
         end
         if (exp_done) begin
            checks++;
            if (last_value !== val_q[0] || regs[dst_q[0]] !== val_q[0]) begin
               errors++;
               $display("FAIL b2b_value cycle %0d: last=%h reg=%h want %h", n, last_value,
                        regs[dst_q[0]], val_q[0]);
            end
            void'(done_at.pop_front());
            void'(dst_q.pop_front());
            void'(val_q.pop_front());
            completed++;
         end
         if (n < 10) begin
            req_valid = 1'b1;
            req_src   = IW'((n + 1) % NR);
            req_dst   = IW'(n % NR);
            req_imm   = DW'($urandom);
            if (n >= next_free) begin
               model_regs[req_dst] = model_regs[req_src];
               done_at.push_back(n + 3);
               dst_q.push_back(req_dst);
               val_q.push_back(model_regs[req_src]);
               next_free = n + 4;
            end
         end else begin
            req_valid = 1'b0;
         end
         @(negedge clock);
      end
      checks++;
      if (completed !== 3) begin
         errors++; $display("FAIL b2b_count: got %0d completions want 3", completed);
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 30; it++) begin
         logic [IW-1:0] s, d;
         logic          ie;
         logic [DW-1:0] im, val;
         bit            bad;
         int            gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) begin
            req_valid = 1'b0;
            req_src   = IW'($urandom);
            req_dst   = IW'($urandom);
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || req_ready !== 1'b1 || oe !== '0 || notLoad !== NL_IDLE) begin
               errors++;
               $display("FAIL rand_idle: done=%b ready=%b oe=%b notLoad=%b", done, req_ready,
                        oe, notLoad);
            end
         end
         s   = IW'($urandom_range(0, 7));
         d   = IW'($urandom_range(0, 7));
         ie  = 1'($urandom_range(0, 1));
         im  = DW'($urandom);
         bad = is_invalid(int'(s), int'(d), ie);
         val = ie ? im : ((int'(s) < NR) ? model_regs[s] : '0);
         send(s, d, ie, im);
         if (bad) begin
            checks++;
            if (done !== 1'b1 || err !== 1'b1 || oe !== '0 || notLoad !== NL_IDLE) begin
               errors++;
               $display("FAIL rand_invalid s=%0d d=%0d ie=%b: done=%b err=%b oe=%b", s, d, ie,
                        done, err, oe);
            end
            @(negedge clock);
         end else begin
            for (int ph = 0; ph < 2; ph++) begin
               logic [NR-1:0] exp_oe, exp_nl;
               exp_oe = ie ? '0 : onehot(int'(s));
               exp_nl = (ph == 1) ? ~onehot(int'(d)) : NL_IDLE;
               checks++;
               if (oe !== exp_oe || notLoad !== exp_nl || bus !== val || done !== 1'b0) begin
                  errors++;
                  $display("FAIL rand_phase%0d s=%0d d=%0d ie=%b: oe=%b/%b nl=%b/%b bus=%h/%h",
                           ph, s, d, ie, oe, exp_oe, notLoad, exp_nl, bus, val);
               end
               @(negedge clock);
            end
            model_regs[d] = val;
            begin
               bit ok;
               ok = 1'b1;
               for (int i = 0; i < NR; i++) if (regs[i] !== model_regs[i]) ok = 1'b0;
               checks++;
               if (done !== 1'b1 || err !== 1'b0 || last_value !== val || !ok) begin
                  errors++;
                  $display("FAIL rand_done s=%0d d=%0d: done=%b err=%b last=%h want %h regs_ok=%b",
                           s, d, done, err, last_value, val, ok);
               end
            end
            @(negedge clock);
         end
         checks++;
         if (req_ready !== 1'b1) begin
            errors++; $display("FAIL rand_ready: got %b want 1", req_ready);
         end
      end
   endtask

   task automatic test_reset_drive();
      send(3'd1, 3'd4, 1'b0, 16'h0);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if (oe !== '0 || notLoad !== NL_IDLE || bus !== BUS_FLOAT || done !== 1'b0 ||
          last_value !== '0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_drive: oe=%b nl=%b bus=%h done=%b last=%h ready=%b", oe, notLoad,
                  bus, done, last_value, req_ready);
      end
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         checks++;
         if (done !== 1'b0 || notLoad !== NL_IDLE || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_drive_after %0d: done=%b nl=%b ready=%b", c, done, notLoad, req_ready);
         end
      end
      begin
         bit ok;
         ok = 1'b1;
         for (int i = 0; i < NR; i++) if (regs[i] !== model_regs[i]) ok = 1'b0;
         checks++;
         if (!ok) begin
            errors++; $display("FAIL rst_drive_regs: register file changed, want untouched");
         end
      end
   endtask

   task automatic test_reset_load();
      logic [DW-1:0] val;
      val = model_regs[0];
      send(3'd0, 3'd3, 1'b0, 16'h0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      model_regs[3] = val;
      checks++;
      if (regs[3] !== val || last_value !== '0 || done !== 1'b0 || oe !== '0) begin
         errors++;
         $display("FAIL rst_load: reg3=%h want %h last=%h want 0 done=%b oe=%b", regs[3], val,
                  last_value, done, oe);
      end
      reset = 1'b0;
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         errors++; $display("FAIL rst_load_after: done=%b ready=%b want 0/1", done, req_ready);
      end
   endtask

   initial begin
      fork
         test_invariants();
      join_none
      test_reset();
      test_reg_to_reg();
      test_immediate();
      test_invalid();
      test_boundary_idx();
      test_back_to_back();
      test_random();
      test_reset_drive();
      test_reset_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/transfer_ctrl.md
TRANSFER_CTRL -- requirements
Module: transfer_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 8: number of bus registers controlled.
REQ-002 SHALL have parameter IDX_WIDTH, default 3: width of register index fields.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: shared data bus width.
REQ-004 SHALL have port clock  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous reset, active-high.
REQ-006 SHALL have port req_valid  input  1: transfer request present.
REQ-007 SHALL have port req_ready  output  1: controller can accept a request this cycle.
REQ-008 SHALL have port req_src  input  IDX_WIDTH: source register index.
REQ-009 SHALL have port req_dst  input  IDX_WIDTH: destination register index.
REQ-010 SHALL have port req_imm_en  input  1: source is req_imm, not a register.
REQ-011 SHALL have port req_imm  input  DATA_WIDTH: immediate value.
REQ-012 SHALL have port oe  output  NUM_REGS: per-register output enable, active-high.
REQ-013 SHALL have port notLoad  output  NUM_REGS: per-register load strobe, active-low.
REQ-014 SHALL have port bus  inout  DATA_WIDTH: shared tri-state data bus.
REQ-015 SHALL have port last_value  output  DATA_WIDTH: bus value captured by the last successful transfer.
REQ-016 SHALL have port done  output  1: one-cycle completion pulse.
REQ-017 SHALL have port err  output  1: qualifies done; request rejected, no transfer performed.

Function
REQ-018 SHALL implement FSM states IDLE, DRIVE, LOAD, DONE.
REQ-019 req_ready SHALL be 1 exactly when state is IDLE and reset is 0.
REQ-020 Acceptance SHALL occur on a rising edge with state IDLE, req_valid=1, reset=0; src, dst, imm_en and imm are latched at that edge.
REQ-021 A latched request SHALL be invalid if dst>=NUM_REGS, or imm_en=0 and (src>=NUM_REGS or src==dst).
REQ-022 Valid request: IDLE->DRIVE->LOAD->DONE->IDLE, one cycle per state; invalid request: IDLE->DONE->IDLE.
REQ-023 In DRIVE and LOAD with imm_en=0, oe[src] SHALL be 1; with imm_en=1, bus SHALL be driven with the latched imm; all other oe bits 0.
REQ-024 bus SHALL be high-Z except during DRIVE/LOAD of an immediate transfer.
REQ-025 In LOAD only, notLoad[dst] SHALL be 0; all other notLoad bits 1 in every state.
REQ-026 At the rising edge ending LOAD, last_value SHALL capture bus.
REQ-027 In DONE, done SHALL be 1, and err SHALL be 1 iff the request was invalid; both SHALL be 0 in all other states.
REQ-028 At most one oe bit SHALL be 1, and no oe bit SHALL be 1 while an immediate is driven.
REQ-029 oe, notLoad, bus enable, done and err SHALL be decoded from registered state only, never from req_* inputs.
REQ-030 Accepted throughput SHALL be one transfer per 4 cycles (valid) or 2 cycles (invalid); req_valid outside IDLE SHALL be ignored.

Reset
REQ-031 On a rising edge with reset=1, the FSM SHALL enter IDLE, last_value SHALL clear to 0, and latched request fields SHALL clear to 0.
REQ-032 While in IDLE, oe SHALL be all 0, notLoad all 1, bus high-Z, done=0 and err=0.
REQ-033 Reset during LOAD SHALL NOT suppress the destination load at that edge, since notLoad is state-decoded; last_value SHALL clear, and done SHALL NOT pulse.
REQ-034 Reset SHALL override a simultaneous req_valid; no request is accepted on a reset edge.

Verification
REQ-035 Reset then reg2 holds 0x1234, request src=2 dst=5 -> oe[2]=1 for 2 cycles, notLoad[5]=0 for 1 cycle, reg5=0x1234, last_value=0x1234, done=1 err=0 at cycle 3.
REQ-036 Immediate request imm=0xBEEF dst=0 -> bus=0xBEEF for 2 cycles with oe all 0, reg0=0xBEEF, done=1 err=0.
REQ-037 Request src=3 dst=3 imm_en=0 -> no oe/notLoad activity, done=1 err=1 in cycle after acceptance, req_ready=1 next cycle.
REQ-038 req_valid held high for 10 cycles with distinct requests -> exactly 3 accepted (every 4th cycle), each completing in order.
REQ-039 reset asserted during DRIVE -> next cycle IDLE, oe all 0, bus high-Z, no notLoad pulse, no done.
REQ-040 Continuous checker: popcount(oe)<=1, notLoad has at most one 0, bus never driven while any oe bit is 1.
